// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: op classes, funct fields,
// operation codes and the sequencer state encoding.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_OP_ADDI  = 4'b0000;
   localparam logic [3:0] ALU_OP_ORI   = 4'b0001;
   localparam logic [3:0] ALU_OP_LUI   = 4'b0010;
   localparam logic [3:0] ALU_OP_ANDI  = 4'b0011;
   localparam logic [3:0] ALU_OP_LW    = 4'b0100;
   localparam logic [3:0] ALU_OP_SW    = 4'b0101;
   localparam logic [3:0] ALU_OP_BEQ   = 4'b0110;
   localparam logic [3:0] ALU_OP_BNE   = 4'b0111;
   localparam logic [3:0] ALU_OP_J     = 4'b1000;
   localparam logic [3:0] ALU_OP_JAL   = 4'b1001;
   localparam logic [3:0] ALU_OP_RTYPE = 4'b1111;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_SRL   = 6'b000010;
   localparam logic [5:0] FUNCT_SLL   = 6'b000000;
   localparam logic [5:0] FUNCT_NOR   = 6'b100111;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_JR    = 6'b001000;

   localparam logic [4:0] OPCODE_ADD     = 5'b00000;
   localparam logic [4:0] OPCODE_SUB     = 5'b00001;
   localparam logic [4:0] OPCODE_OR      = 5'b00010;
   localparam logic [4:0] OPCODE_ORI     = 5'b00011;
   localparam logic [4:0] OPCODE_SRL     = 5'b00100;
   localparam logic [4:0] OPCODE_SLL     = 5'b00101;
   localparam logic [4:0] OPCODE_LUI     = 5'b00110;
   localparam logic [4:0] OPCODE_ANDI    = 5'b00111;
   localparam logic [4:0] OPCODE_LW      = 5'b01000;
   localparam logic [4:0] OPCODE_SW      = 5'b01001;
   localparam logic [4:0] OPCODE_BEQ     = 5'b01010;
   localparam logic [4:0] OPCODE_BNE     = 5'b01011;
   localparam logic [4:0] OPCODE_NOR     = 5'b01100;
   localparam logic [4:0] OPCODE_AND     = 5'b01101;
   localparam logic [4:0] OPCODE_J       = 5'b01110;
   localparam logic [4:0] OPCODE_JAL     = 5'b01111;
   localparam logic [4:0] OPCODE_MULT    = 5'b10000;
   localparam logic [4:0] OPCODE_MULTU   = 5'b10001;
   localparam logic [4:0] OPCODE_DIV     = 5'b10010;
   localparam logic [4:0] OPCODE_DIVU    = 5'b10011;
   localparam logic [4:0] OPCODE_MFHI    = 5'b10100;
   localparam logic [4:0] OPCODE_MFLO    = 5'b10101;
   localparam logic [4:0] OPCODE_SLT     = 5'b10110;
   localparam logic [4:0] OPCODE_JR      = 5'b10111;
   localparam logic [4:0] OPCODE_ILLEGAL = 5'b11111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } seq_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Pure combinational decode of {alu_op, funct} into an operation code plus
// mul/div classification flags.
module alu_op_decoder
   import alu_ctrl_pkg::*;
#(
   parameter int ALU_OP_WIDTH    = 4,
   parameter int FUNCT_WIDTH     = 6,
   parameter int OPERATION_WIDTH = 5,
   parameter int ENABLE_MULDIV   = 1
) (
   input  logic [ALU_OP_WIDTH-1:0]    alu_op_i,
   input  logic [FUNCT_WIDTH-1:0]     alu_function_i,
   output logic [OPERATION_WIDTH-1:0] operation_o,
   output logic                       is_muldiv_o,
   output logic                       is_div_o,
   output logic                       is_signed_o,
   output logic                       illegal_o
);

   localparam bit MD_EN = (ENABLE_MULDIV != 0);

   logic [4:0] code_s;
   logic       muldiv_s;
   logic       div_s;
   logic       signed_s;

   // Decode table; mul/div-related functs fall back to illegal when the unit is absent
   always_comb begin
      code_s   = OPCODE_ILLEGAL;
      muldiv_s = 1'b0;
      div_s    = 1'b0;
      signed_s = 1'b0;
      case (alu_op_i)
         ALU_OP_WIDTH'(ALU_OP_ADDI): code_s = OPCODE_ADD;
         ALU_OP_WIDTH'(ALU_OP_ORI):  code_s = OPCODE_ORI;
         ALU_OP_WIDTH'(ALU_OP_LUI):  code_s = OPCODE_LUI;
         ALU_OP_WIDTH'(ALU_OP_ANDI): code_s = OPCODE_ANDI;
         ALU_OP_WIDTH'(ALU_OP_LW):   code_s = OPCODE_LW;
         ALU_OP_WIDTH'(ALU_OP_SW):   code_s = OPCODE_SW;
         ALU_OP_WIDTH'(ALU_OP_BEQ):  code_s = OPCODE_BEQ;
         ALU_OP_WIDTH'(ALU_OP_BNE):  code_s = OPCODE_BNE;
         ALU_OP_WIDTH'(ALU_OP_J):    code_s = OPCODE_J;
         ALU_OP_WIDTH'(ALU_OP_JAL):  code_s = OPCODE_JAL;
         ALU_OP_WIDTH'(ALU_OP_RTYPE): begin
            case (alu_function_i)
               FUNCT_WIDTH'(FUNCT_ADD): code_s = OPCODE_ADD;
               FUNCT_WIDTH'(FUNCT_SUB): code_s = OPCODE_SUB;
               FUNCT_WIDTH'(FUNCT_OR):  code_s = OPCODE_OR;
               FUNCT_WIDTH'(FUNCT_SRL): code_s = OPCODE_SRL;
               FUNCT_WIDTH'(FUNCT_SLL): code_s = OPCODE_SLL;
               FUNCT_WIDTH'(FUNCT_NOR): code_s = OPCODE_NOR;
               FUNCT_WIDTH'(FUNCT_AND): code_s = OPCODE_AND;
               FUNCT_WIDTH'(FUNCT_SLT): code_s = OPCODE_SLT;
               FUNCT_WIDTH'(FUNCT_JR):  code_s = OPCODE_JR;
               FUNCT_WIDTH'(FUNCT_MFHI): code_s = MD_EN ? OPCODE_MFHI : OPCODE_ILLEGAL;
               FUNCT_WIDTH'(FUNCT_MFLO): code_s = MD_EN ? OPCODE_MFLO : OPCODE_ILLEGAL;
               FUNCT_WIDTH'(FUNCT_MULT): begin
                  code_s   = MD_EN ? OPCODE_MULT : OPCODE_ILLEGAL;
                  muldiv_s = MD_EN;
                  signed_s = MD_EN;
               end
               FUNCT_WIDTH'(FUNCT_MULTU): begin
                  code_s   = MD_EN ? OPCODE_MULTU : OPCODE_ILLEGAL;
                  muldiv_s = MD_EN;
               end
               FUNCT_WIDTH'(FUNCT_DIV): begin
                  code_s   = MD_EN ? OPCODE_DIV : OPCODE_ILLEGAL;
                  muldiv_s = MD_EN;
                  div_s    = MD_EN;
                  signed_s = MD_EN;
               end
               FUNCT_WIDTH'(FUNCT_DIVU): begin
                  code_s   = MD_EN ? OPCODE_DIVU : OPCODE_ILLEGAL;
                  muldiv_s = MD_EN;
                  div_s    = MD_EN;
               end
               default: code_s = OPCODE_ILLEGAL;
            endcase
         end
         default: code_s = OPCODE_ILLEGAL;
      endcase
   end

   assign operation_o = OPERATION_WIDTH'(code_s);
   assign is_muldiv_o = muldiv_s;
   assign is_div_o    = div_s;
   assign is_signed_o = signed_s;
   assign illegal_o   = (code_s == OPCODE_ILLEGAL);

endmodule

// File: rtl/alu_control_sequencer.sv
// ALU control unit: registers decoded operation codes and sequences multi-cycle
// mul/div operations, stalling the front end until the HI/LO write has happened.
module alu_control_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int ALU_OP_WIDTH    = 4,
   parameter int FUNCT_WIDTH     = 6,
   parameter int OPERATION_WIDTH = 5,
   parameter int MULT_CYCLES     = 4,
   parameter int DIV_CYCLES      = 32,
   parameter int ENABLE_MULDIV   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_i,
   input  logic [ALU_OP_WIDTH-1:0]    alu_op_i,
   input  logic [FUNCT_WIDTH-1:0]     alu_function_i,
   input  logic                       flush_i,
   output logic                       ready_o,
   output logic [OPERATION_WIDTH-1:0] alu_operation_o,
   output logic                       op_valid_o,
   output logic                       illegal_o,
   output logic                       muldiv_start_o,
   output logic                       muldiv_is_div_o,
   output logic                       muldiv_signed_o,
   output logic                       hilo_we_o,
   output logic                       stall_o
);

   localparam int CNT_WIDTH = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
   localparam logic [CNT_WIDTH-1:0] MULT_LOAD = CNT_WIDTH'(MULT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] DIV_LOAD  = CNT_WIDTH'(DIV_CYCLES - 1);

   logic [OPERATION_WIDTH-1:0] dec_op_s;
   logic dec_muldiv_s, dec_div_s, dec_signed_s, dec_illegal_s;
   logic accept_s;

   seq_state_e                 state_q, state_d;
   logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
   logic [OPERATION_WIDTH-1:0] op_q, op_d;
   logic op_valid_q, op_valid_d;
   logic illegal_q, illegal_d;
   logic start_q, start_d;
   logic is_div_q, is_div_d;
   logic signed_q, signed_d;
   logic hilo_we_q, hilo_we_d;

   alu_op_decoder #(
      .ALU_OP_WIDTH    (ALU_OP_WIDTH),
      .FUNCT_WIDTH     (FUNCT_WIDTH),
      .OPERATION_WIDTH (OPERATION_WIDTH),
      .ENABLE_MULDIV   (ENABLE_MULDIV)
   ) u_decoder (
      .alu_op_i       (alu_op_i),
      .alu_function_i (alu_function_i),
      .operation_o    (dec_op_s),
      .is_muldiv_o    (dec_muldiv_s),
      .is_div_o       (dec_div_s),
      .is_signed_o    (dec_signed_s),
      .illegal_o      (dec_illegal_s)
   );

   // A request arriving together with a flush is dropped
   assign accept_s = valid_i && (state_q == ST_IDLE) && !flush_i;

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= '1;
         op_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
         start_q    <= 1'b0;
         is_div_q   <= 1'b0;
         signed_q   <= 1'b0;
         hilo_we_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         op_valid_q <= op_valid_d;
         illegal_q  <= illegal_d;
         start_q    <= start_d;
         is_div_q   <= is_div_d;
         signed_q   <= signed_d;
         hilo_we_q  <= hilo_we_d;
      end
   end

   // Next-state and latency counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s && dec_muldiv_s) begin
                  state_d = ST_BUSY;
                  cnt_d   = dec_div_s ? DIV_LOAD : MULT_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (cnt_q == '0) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_d = cnt_q - CNT_WIDTH'(1);
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Next values of the registered outputs
   always_comb begin
      op_d       = op_q;
      op_valid_d = 1'b0;
      illegal_d  = 1'b0;
      start_d    = 1'b0;
      hilo_we_d  = 1'b0;
      is_div_d   = is_div_q;
      signed_d   = signed_q;
      if (flush_i) begin
         is_div_d = 1'b0;
         signed_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_s) begin
                  op_d = dec_op_s;
                  if (dec_muldiv_s) begin
                     start_d  = 1'b1;
                     is_div_d = dec_div_s;
                     signed_d = dec_signed_s;
                  end else begin
                     op_valid_d = 1'b1;
                     illegal_d  = dec_illegal_s;
                  end
               end else begin
                  op_d = op_q;
               end
            end
            ST_BUSY: begin
               if (cnt_q == '0) begin
                  hilo_we_d  = 1'b1;
                  op_valid_d = 1'b1;
               end else begin
                  hilo_we_d = 1'b0;
               end
            end
            ST_DONE: begin
               is_div_d = 1'b0;
               signed_d = 1'b0;
            end
            default: begin
               is_div_d = 1'b0;
               signed_d = 1'b0;
            end
         endcase
      end
   end

   assign ready_o         = (state_q == ST_IDLE);
   assign stall_o         = (state_q == ST_BUSY);
   assign alu_operation_o = op_q;
   assign op_valid_o      = op_valid_q;
   assign illegal_o       = illegal_q;
   assign muldiv_start_o  = start_q;
   assign muldiv_is_div_o = is_div_q;
   assign muldiv_signed_o = signed_q;
   assign hilo_we_o       = hilo_we_q;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed self-checking bench for alu_control_sequencer (default build plus a
// build without the mul/div unit).
module tb_alu_control_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic       flush = 1'b0;
   logic [3:0] alu_op = 4'b0000;
   logic [5:0] funct = 6'b000000;

   logic       ready, op_valid, illegal, start, is_div, is_signed, hilo, stall;
   logic [4:0] op;
   logic       n_ready, n_op_valid, n_illegal, n_start, n_is_div, n_is_signed, n_hilo, n_stall;
   logic [4:0] n_op;

   int compared = 0;
   int mismatched = 0;

   // {ready, op_valid, illegal, start, stall, hilo}
   wire [5:0] flags   = {ready, op_valid, illegal, start, stall, hilo};
   wire [5:0] n_flags = {n_ready, n_op_valid, n_illegal, n_start, n_stall, n_hilo};

   alu_control_sequencer dut (
      .clk(clk), .reset(reset), .valid_i(valid), .alu_op_i(alu_op), .alu_function_i(funct),
      .flush_i(flush), .ready_o(ready), .alu_operation_o(op), .op_valid_o(op_valid),
      .illegal_o(illegal), .muldiv_start_o(start), .muldiv_is_div_o(is_div),
      .muldiv_signed_o(is_signed), .hilo_we_o(hilo), .stall_o(stall)
   );

   alu_control_sequencer #(.ENABLE_MULDIV(0)) dut_nomd (
      .clk(clk), .reset(reset), .valid_i(valid), .alu_op_i(alu_op), .alu_function_i(funct),
      .flush_i(flush), .ready_o(n_ready), .alu_operation_o(n_op), .op_valid_o(n_op_valid),
      .illegal_o(n_illegal), .muldiv_start_o(n_start), .muldiv_is_div_o(n_is_div),
      .muldiv_signed_o(n_is_signed), .hilo_we_o(n_hilo), .stall_o(n_stall)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      compared++;
      if ({op, flags, is_div, is_signed} !== {5'b11111, 6'b100000, 2'b00}) begin
         mismatched++;
         $display("FAIL reset_state: got op=%b flags=%b div/sgn=%b%b, expected op=11111 flags=100000 div/sgn=00",
                  op, flags, is_div, is_signed);
      end
      reset = 1'b0;
      tick();
      compared++;
      if ({op, flags} !== {5'b11111, 6'b100000}) begin
         mismatched++;
         $display("FAIL reset_idle: got op=%b flags=%b, expected op=11111 flags=100000", op, flags);
      end
   endtask

   task automatic test_add;
      valid = 1'b1; alu_op = 4'b1111; funct = 6'b100000;
      tick();
      valid = 1'b0;
      compared++;
      if ({op, flags} !== {5'b00000, 6'b110000}) begin
         mismatched++;
         $display("FAIL add_decode: got op=%b flags=%b, expected op=00000 flags=110000", op, flags);
      end
      tick();
      compared++;
      if ({op, flags} !== {5'b00000, 6'b100000}) begin
         mismatched++;
         $display("FAIL add_hold: got op=%b flags=%b, expected op=00000 flags=100000", op, flags);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] ops [3] = '{4'b0001, 4'b0111, 4'b1001};
      logic [4:0] exp [3] = '{5'b00011, 5'b01011, 5'b01111};
      funct = 6'b000000;
      for (int i = 0; i < 3; i++) begin
         valid = 1'b1; alu_op = ops[i];
         tick();
         compared++;
         if ({op, flags} !== {exp[i], 6'b110000}) begin
            mismatched++;
            $display("FAIL b2b_%0d: got op=%b flags=%b, expected op=%b flags=110000", i, op, flags, exp[i]);
         end
      end
      valid = 1'b0;
      tick();
      compared++;
      if ({op, flags} !== {5'b01111, 6'b100000}) begin
         mismatched++;
         $display("FAIL b2b_idle: got op=%b flags=%b, expected op=01111 flags=100000", op, flags);
      end
   endtask

   task automatic test_decode_table;
      logic [3:0] ops [7] = '{4'b1111, 4'b1111, 4'b0010, 4'b1111, 4'b1111, 4'b1111, 4'b1000};
      logic [5:0] fns [7] = '{6'b100010, 6'b000010, 6'b000000, 6'b010010, 6'b101010, 6'b001000, 6'b000000};
      logic [4:0] exp [7] = '{5'b00001, 5'b00100, 5'b00110, 5'b10101, 5'b10110, 5'b10111, 5'b01110};
      for (int i = 0; i < 7; i++) begin
         valid = 1'b1; alu_op = ops[i]; funct = fns[i];
         tick();
         compared++;
         if ({op, flags} !== {exp[i], 6'b110000}) begin
            mismatched++;
            $display("FAIL decode_%0d: got op=%b flags=%b, expected op=%b flags=110000", i, op, flags, exp[i]);
         end
      end
      valid = 1'b0;
      tick();
   endtask

   task automatic test_mult;
      valid = 1'b1; alu_op = 4'b1111; funct = 6'b011000;
      tick();
      valid = 1'b0;
      compared++;
      if ({op, flags, is_div, is_signed} !== {5'b10000, 6'b000110, 2'b01}) begin
         mismatched++;
         $display("FAIL mult_start: got op=%b flags=%b div/sgn=%b%b, expected op=10000 flags=000110 div/sgn=01",
                  op, flags, is_div, is_signed);
      end
      for (int i = 1; i < 4; i++) begin
         tick();
         compared++;
         if ({flags, is_signed} !== {6'b000010, 1'b1}) begin
            mismatched++;
            $display("FAIL mult_busy_%0d: got flags=%b sgn=%b, expected flags=000010 sgn=1", i, flags, is_signed);
         end
      end
      tick();
      compared++;
      if ({op, flags} !== {5'b10000, 6'b010001}) begin
         mismatched++;
         $display("FAIL mult_done: got op=%b flags=%b, expected op=10000 flags=010001", op, flags);
      end
      tick();
      compared++;
      if (flags !== 6'b100000) begin
         mismatched++;
         $display("FAIL mult_ready: got flags=%b, expected 100000", flags);
      end
   endtask

   task automatic test_flush_divu;
      int hilo_seen = 0;
      valid = 1'b1; alu_op = 4'b1111; funct = 6'b011011;
      tick();
      valid = 1'b0;
      compared++;
      if ({op, flags, is_div, is_signed} !== {5'b10011, 6'b000110, 2'b10}) begin
         mismatched++;
         $display("FAIL divu_start: got op=%b flags=%b div/sgn=%b%b, expected op=10011 flags=000110 div/sgn=10",
                  op, flags, is_div, is_signed);
      end
      for (int i = 0; i < 9; i++) tick();
      compared++;
      if (flags !== 6'b000010) begin
         mismatched++;
         $display("FAIL divu_busy: got flags=%b, expected 000010", flags);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      compared++;
      if ({flags, is_div} !== {6'b100000, 1'b0}) begin
         mismatched++;
         $display("FAIL divu_flush: got flags=%b div=%b, expected flags=100000 div=0", flags, is_div);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (hilo || op_valid) hilo_seen++;
      end
      compared++;
      if (hilo_seen !== 0) begin
         mismatched++;
         $display("FAIL divu_no_hilo: got %0d pulse cycles, expected 0", hilo_seen);
      end
      valid = 1'b1; flush = 1'b1; funct = 6'b100000;
      tick();
      valid = 1'b0; flush = 1'b0;
      compared++;
      if ({op, flags} !== {5'b10011, 6'b100000}) begin
         mismatched++;
         $display("FAIL flush_drop: got op=%b flags=%b, expected op=10011 flags=100000", op, flags);
      end
   endtask

   task automatic test_illegal;
      logic [3:0] ops [2] = '{4'b1111, 4'b1010};
      logic [5:0] fns [2] = '{6'b111111, 6'b000000};
      for (int i = 0; i < 2; i++) begin
         valid = 1'b1; alu_op = ops[i]; funct = fns[i];
         tick();
         compared++;
         if ({op, flags} !== {5'b11111, 6'b111000}) begin
            mismatched++;
            $display("FAIL illegal_%0d: got op=%b flags=%b, expected op=11111 flags=111000", i, op, flags);
         end
      end
      valid = 1'b0;
      tick();
      compared++;
      if (flags !== 6'b100000) begin
         mismatched++;
         $display("FAIL illegal_pulse: got flags=%b, expected 100000", flags);
      end
   endtask

   task automatic test_no_muldiv;
      valid = 1'b1; alu_op = 4'b1111; funct = 6'b011010;
      tick();
      valid = 1'b0;
      compared++;
      if ({n_op, n_flags} !== {5'b11111, 6'b111000}) begin
         mismatched++;
         $display("FAIL nomd_div: got op=%b flags=%b, expected op=11111 flags=111000", n_op, n_flags);
      end
      compared++;
      if ({op, flags, is_div, is_signed} !== {5'b10010, 6'b000110, 2'b11}) begin
         mismatched++;
         $display("FAIL div_start: got op=%b flags=%b div/sgn=%b%b, expected op=10010 flags=000110 div/sgn=11",
                  op, flags, is_div, is_signed);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_reset_mid_div;
      int hilo_seen = 0;
      valid = 1'b1; alu_op = 4'b1111; funct = 6'b011010;
      tick();
      valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      compared++;
      if (flags !== 6'b000010) begin
         mismatched++;
         $display("FAIL rdiv_busy: got flags=%b, expected 000010", flags);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      compared++;
      if ({op, flags, is_div, is_signed} !== {5'b11111, 6'b100000, 2'b00}) begin
         mismatched++;
         $display("FAIL rdiv_reset: got op=%b flags=%b div/sgn=%b%b, expected op=11111 flags=100000 div/sgn=00",
                  op, flags, is_div, is_signed);
      end
      valid = 1'b1; funct = 6'b100000;
      tick();
      valid = 1'b0;
      compared++;
      if ({op, flags} !== {5'b00000, 6'b110000}) begin
         mismatched++;
         $display("FAIL rdiv_add: got op=%b flags=%b, expected op=00000 flags=110000", op, flags);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (hilo) hilo_seen++;
      end
      compared++;
      if (hilo_seen !== 0) begin
         mismatched++;
         $display("FAIL rdiv_no_hilo: got %0d hilo cycles, expected 0", hilo_seen);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_decode_table();
      test_mult();
      test_flush_divu();
      test_illegal();
      test_no_muldiv();
      test_reset_mid_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
